// File: rtl/expr_string_tx_if.sv
// Load/stream bundle for the expression-string transmitter.
// master = load requester and byte sink, slave = the transmitter.
interface expr_string_tx_if #(
   parameter int MAX_TERMS = 8,
   parameter int CNT_W     = $clog2(MAX_TERMS + 1)
);
   localparam int OPS_W = (MAX_TERMS > 1) ? MAX_TERMS - 1 : 1;

   logic                   start;
   logic [CNT_W-1:0]       num_terms;
   logic [4*MAX_TERMS-1:0] digits;
   logic [OPS_W-1:0]       ops;
   logic [7:0]             out_byte;
   logic                   out_valid;
   logic                   out_ready;
   logic                   out_last;
   logic                   busy;
   logic                   done;
   logic                   err;

   modport master (
      output start, num_terms, digits, ops, out_ready,
      input  out_byte, out_valid, out_last, busy, done, err
   );

   modport slave (
      input  start, num_terms, digits, ops, out_ready,
      output out_byte, out_valid, out_last, busy, done, err
   );
endinterface

// File: rtl/expr_string_tx.sv
// Byte-serial transmitter: streams "digit (op digit)*" as ASCII from a
// parallel-loaded list of BCD terms and operator selects.
module expr_string_tx #(
   parameter int MAX_TERMS = 8,
   parameter int CNT_W     = $clog2(MAX_TERMS + 1)
) (
   input logic             clk,
   input logic             clr,
   expr_string_tx_if.slave bus
);
   localparam int OPS_W = (MAX_TERMS > 1) ? MAX_TERMS - 1 : 1;

   typedef enum logic [1:0] {S_IDLE, S_DIGIT, S_OP, S_FINISH} state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       idx_q, idx_d;
   logic [CNT_W-1:0]       n_q, n_d;
   logic [4*MAX_TERMS-1:0] dig_q, dig_d;
   logic [OPS_W-1:0]       ops_q, ops_d;
   logic [7:0]             out_byte_q, out_byte_d;
   logic                   out_valid_q, out_valid_d;
   logic                   out_last_q, out_last_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;

   logic                   req_ok;
   logic                   hs;
   logic [CNT_W-1:0]       idx_nx;
   logic [CNT_W-1:0]       last_idx;
   logic [4*MAX_TERMS-1:0] dig_sh;
   logic [OPS_W-1:0]       ops_sh;

   // A request is legal when n is in range and every used term is BCD.
   always_comb begin
      req_ok = (bus.num_terms != '0) && (bus.num_terms <= CNT_W'(MAX_TERMS));
      for (int i = 0; i < MAX_TERMS; i++) begin
         if (i < int'(bus.num_terms) && bus.digits[4*i +: 4] > 4'd9) req_ok = 1'b0;
      end
   end

   assign hs       = out_valid_q && bus.out_ready;
   assign idx_nx   = idx_q + CNT_W'(1);
   assign last_idx = n_q - CNT_W'(1);
   assign dig_sh   = dig_q >> {idx_nx, 2'b00};
   assign ops_sh   = ops_q >> idx_q;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a variable unassigned and no latch is inferred.
      state_d     = state_q;
      idx_d       = idx_q;
      n_d         = n_q;
      dig_d       = dig_q;
      ops_d       = ops_q;
      out_byte_d  = out_byte_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      err_d       = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               if (req_ok) begin
                  n_d         = bus.num_terms;
                  dig_d       = bus.digits;
                  ops_d       = bus.ops;
                  idx_d       = '0;
                  busy_d      = 1'b1;
                  out_byte_d  = 8'h30 + {4'h0, bus.digits[3:0]};
                  out_valid_d = 1'b1;
                  out_last_d  = (bus.num_terms == CNT_W'(1));
                  state_d     = S_DIGIT;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_DIGIT: begin
            if (hs) begin
               if (idx_q == last_idx) begin
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  busy_d      = 1'b0;
                  done_d      = 1'b1;
                  state_d     = S_FINISH;
               end else begin
                  out_byte_d = ops_sh[0] ? 8'h2A : 8'h2B;
                  out_last_d = 1'b0;
                  state_d    = S_OP;
               end
            end
         end
         S_OP: begin
            // Advance to the term after this operator.
            if (hs) begin
               idx_d      = idx_nx;
               out_byte_d = 8'h30 + {4'h0, dig_sh[3:0]};
               out_last_d = (idx_nx == last_idx);
               state_d    = S_DIGIT;
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         out_byte_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         out_byte_q  <= out_byte_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   // NOTE: the shadow copies are deliberately left without reset; they are
   // only read after a load has overwritten them.
   always_ff @(posedge clk) begin
      n_q   <= n_d;
      dig_q <= dig_d;
      ops_q <= ops_d;
   end

   assign bus.out_byte  = out_byte_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_last  = out_last_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_expr_string_tx.sv
// Self-checking bench for expr_string_tx: vector table, hand-written corner
// sequences and random streams checked against an ASCII-string model.
module tb_expr_string_tx;
   localparam int MAX_TERMS = 8;
   localparam int CNT_W     = $clog2(MAX_TERMS + 1);
   localparam int OPS_W     = MAX_TERMS - 1;

   logic clk = 1'b0;
   logic clr;

   expr_string_tx_if #(.MAX_TERMS(MAX_TERMS)) bus ();
   expr_string_tx #(.MAX_TERMS(MAX_TERMS)) dut (.clk(clk), .clr(clr), .bus(bus));

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int                     n;
      logic [4*MAX_TERMS-1:0] digits;
      logic [OPS_W-1:0]       ops;
      bit                     exp_err;
      int                     mode;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // 0: always ready, 1: repeating 0,1,0,0,1, 2: random (mostly ready)
   function automatic bit ready_for(input int mode, input int cyc);
      bit pat [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      if (mode == 0) return 1'b1;
      if (mode == 1) return pat[cyc % 5];
      return ($urandom_range(0, 3) != 0);
   endfunction

   task automatic start_req(input int n, input logic [4*MAX_TERMS-1:0] d, input logic [OPS_W-1:0] o);
      bus.start     = 1'b1;
      bus.num_terms = CNT_W'(n);
      bus.digits    = d;
      bus.ops       = o;
      step();
      bus.start = 1'b0;
   endtask

   // Called with the first byte already offered; sinks the whole stream.
   task automatic run_stream(input int n, input logic [4*MAX_TERMS-1:0] d,
                             input logic [OPS_W-1:0] o, input int mode, input bit poke_start);
      logic [7:0] exp_q [$];
      logic [7:0] want;
      logic [7:0] prev_byte;
      logic [7:0] ob;
      int         cyc;
      int         total;
      bit         hs;
      bit         prev_hs;
      bit         expect_digit;
      bit         rec_out;
      bit         accepted;

      for (int i = 0; i < n; i++) begin
         exp_q.push_back(8'h30 + {4'h0, d[4*i +: 4]});
         if (i < n - 1) exp_q.push_back(o[i] ? "*" : "+");
      end
      total        = exp_q.size();
      cyc          = 0;
      prev_hs      = 1'b1;
      prev_byte    = 8'h00;
      expect_digit = 1'b1;
      rec_out      = 1'b0;

      while (exp_q.size() != 0 && cyc < 400) begin
         bus.out_ready = ready_for(mode, cyc);
         if (poke_start) begin
            bus.start     = 1'b1;
            bus.num_terms = CNT_W'(cyc % 2);
            bus.digits    = '0;
         end
         check("busy_during", bus.busy, 1);
         check("valid_during", bus.out_valid, 1);
         check("err_during", bus.err, 0);
         check("done_during", bus.done, 0);
         if (!prev_hs) check("hold_byte", bus.out_byte, prev_byte);
         hs = bus.out_valid && bus.out_ready;
         if (hs) begin
            want = exp_q.pop_front();
            ob   = bus.out_byte;
            check("byte", ob, want);
            check("last", bus.out_last, exp_q.size() == 0);
            accepted = expect_digit ? (ob >= "0" && ob <= "9") : (ob == "+" || ob == "*");
            check("recognizer", accepted, 1);
            rec_out      = expect_digit;
            expect_digit = !expect_digit;
         end
         prev_hs   = hs;
         prev_byte = bus.out_byte;
         step();
         cyc++;
      end
      bus.start = 1'b0;

      check("stream_complete", exp_q.size(), 0);
      if (mode == 0) check("no_bubbles", cyc, total);
      check("rec_final", rec_out, 1);
      check("done_pulse", bus.done, 1);
      check("busy_end", bus.busy, 0);
      check("valid_end", bus.out_valid, 0);
      check("last_end", bus.out_last, 0);
      step();
      check("done_clear", bus.done, 0);
      check("err_idle", bus.err, 0);
   endtask

   task automatic apply_vector(input vec_t v);
      start_req(v.n, v.digits, v.ops);
      check("err_pulse", bus.err, v.exp_err);
      if (v.exp_err) begin
         check("rej_valid", bus.out_valid, 0);
         check("rej_busy", bus.busy, 0);
         step();
         check("err_one_cycle", bus.err, 0);
         check("rej_valid2", bus.out_valid, 0);
         check("rej_busy2", bus.busy, 0);
      end else begin
         run_stream(v.n, v.digits, v.ops, v.mode, 1'b0);
      end
   endtask

   vec_t vecs [8];

   initial begin
      logic [4*MAX_TERMS-1:0] rd;
      logic [OPS_W-1:0]       ro;
      int                     rn;

      bus.start     = 1'b0;
      bus.num_terms = '0;
      bus.digits    = '0;
      bus.ops       = '0;
      bus.out_ready = 1'b0;
      clr           = 1'b1;
      step();
      step();
      clr = 1'b0;
      check("rst_byte", bus.out_byte, 0);
      check("rst_valid", bus.out_valid, 0);
      check("rst_last", bus.out_last, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_err", bus.err, 0);

      // ready while idle must not disturb anything
      bus.out_ready = 1'b1;
      step();
      check("idle_ready_valid", bus.out_valid, 0);

      vecs[0] = '{3, 32'h0000_0321, 7'b000_0010, 1'b0, 0};
      vecs[1] = '{3, 32'h0000_0321, 7'b000_0010, 1'b0, 1};
      vecs[2] = '{1, 32'h0000_0009, 7'b000_0000, 1'b0, 0};
      vecs[3] = '{2, 32'h0000_00A1, 7'b000_0000, 1'b1, 0};
      vecs[4] = '{0, 32'h0000_0000, 7'b000_0000, 1'b1, 0};
      vecs[5] = '{9, 32'h0000_0000, 7'b000_0000, 1'b1, 0};
      vecs[6] = '{8, 32'h9876_5432, 7'b101_0101, 1'b0, 2};
      vecs[7] = '{2, 32'hFFFF_FF05, 7'b111_1110, 1'b0, 0};
      for (int k = 0; k < 8; k++) apply_vector(vecs[k]);

      // Start held high during a stream is ignored.
      bus.out_ready = 1'b1;
      start_req(3, 32'h0000_0547, 7'b000_0001);
      run_stream(3, 32'h0000_0547, 7'b000_0001, 1, 1'b1);

      // Abort after two handshakes, then a fresh stream from term 0.
      bus.out_ready = 1'b1;
      start_req(4, 32'h0000_4321, 7'b000_0101);
      step();
      step();
      check("pre_abort_byte", bus.out_byte, 8'h32);
      clr = 1'b1;
      step();
      clr = 1'b0;
      bus.out_ready = 1'b0;
      check("abort_byte", bus.out_byte, 0);
      check("abort_valid", bus.out_valid, 0);
      check("abort_last", bus.out_last, 0);
      check("abort_busy", bus.busy, 0);
      check("abort_done", bus.done, 0);
      check("abort_err", bus.err, 0);
      step();
      check("abort_no_done", bus.done, 0);
      start_req(4, 32'h0000_8765, 7'b000_0010);
      run_stream(4, 32'h0000_8765, 7'b000_0010, 0, 1'b0);

      // Random streams with a random sink.
      for (int k = 0; k < 24; k++) begin
         rn = (k < 12) ? MAX_TERMS : int'($urandom_range(1, MAX_TERMS));
         rd = '0;
         for (int i = 0; i < MAX_TERMS; i++) rd[4*i +: 4] = 4'($urandom_range(0, 9));
         ro = OPS_W'($urandom);
         bus.out_ready = 1'($urandom);
         step();
         check("rand_idle_valid", bus.out_valid, 0);
         start_req(rn, rd, ro);
         check("rand_err", bus.err, 0);
         run_stream(rn, rd, ro, 2, (k % 3) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time limit so the bench always terminates.
   initial begin
      #500000;
      $display("FAIL timeout: got no finish, want finish before 500000");
      $fatal(1, "timeout");
   end
endmodule
